adc_serial_capture: RTL

- Upstream front-end for one hydrophone channel. Drives a 16-bit SAR ADC with a serial interface (CNV/SCK/SDO) at a fixed sample rate.
- Deserialises each conversion and presents it as ADC_O_data with a one-cycle ADC_O_dataValid strobe.
- These outputs connect directly to the ADC_I_data / ADC_I_dataValid inputs of the channel's dual-port capture RAM interface, replacing the constant tie-offs.
- Four instances are used, one per channel, all on the ADC clock.

---
 rtl/adc_serial_capture_if.sv | 39 +++
 rtl/adc_serial_capture.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/adc_serial_capture_if.sv
// Purpose: groups the run control, ADC serial pins and sample output of one capture channel.
// Latency: none, wiring only.
// Backpressure: none; the sample strobe is a fire-and-forget pulse.
interface adc_serial_capture_if #(
  parameter int DATA_W = 16
);
  logic              I_enable;
  logic              ADC_O_cnv;
  logic              ADC_O_sck;
  logic              ADC_I_sdo;
  logic [DATA_W-1:0] ADC_O_data;
  logic              ADC_O_dataValid;
  logic              O_busy;
  logic              O_overrun;

  // Capture block side: drives the ADC pins and the sample output
  modport master (
    input  I_enable,
    input  ADC_I_sdo,
    output ADC_O_cnv,
    output ADC_O_sck,
    output ADC_O_data,
    output ADC_O_dataValid,
    output O_busy,
    output O_overrun
  );

  // Environment side: run control, ADC data pin, and the sample consumer
  modport slave (
    output I_enable,
    output ADC_I_sdo,
    input  ADC_O_cnv,
    input  ADC_O_sck,
    input  ADC_O_data,
    input  ADC_O_dataValid,
    input  O_busy,
    input  O_overrun
  );
endinterface

// File: rtl/adc_serial_capture.sv
// Purpose: periodic SAR ADC sequencer (CNV pulse, SCK burst) deserialising one DATA_W-bit sample per tick.
// Latency: dataValid at tick + CONV_CYCLES + 2*CLK_DIV*DATA_W + 1 cycles.
// Backpressure: none; a tick that arrives while a sample is in flight is dropped and flagged as overrun.
module adc_serial_capture #(
  parameter int DATA_W        = 16,
  parameter int CLK_DIV       = 2,
  parameter int CONV_CYCLES   = 100,
  parameter int SAMPLE_PERIOD = 500
) (
  input logic                  ADC_I_clk,
  input logic                  I_rst,
  adc_serial_capture_if.master bus
);

  localparam int TICK_W = $clog2(SAMPLE_PERIOD);
  localparam int CONV_W = $clog2(CONV_CYCLES + 1);
  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int BIT_W  = $clog2(DATA_W + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_PERIOD - 1);
  localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_READ,
    S_DONE
  } state_t;

  state_t              r_state;
  logic                r_en_q;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [CONV_W-1:0]   r_conv_cnt;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   r_data;
  logic                r_cnv;
  logic                r_sck;
  logic                r_valid;
  logic                r_busy;
  logic                r_overrun;

  logic                w_run;
  logic                w_tick;
  logic [DATA_W-1:0]   w_shift_nxt;

  // The counter only runs once enable has been high for a full cycle, so the
  // first tick lands SAMPLE_PERIOD cycles after enable rises.
  assign w_run       = bus.I_enable & r_en_q;
  assign w_tick      = w_run & (r_tick_cnt == TICK_LAST);
  assign w_shift_nxt = {r_shift[DATA_W-2:0], bus.ADC_I_sdo};

  // Sample-rate tick counter: wraps at SAMPLE_PERIOD-1, held at zero while disabled
  always_ff @(posedge ADC_I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_en_q     <= 1'b0;
      r_tick_cnt <= '0;
    end else begin
      r_en_q <= bus.I_enable;
      if (!w_run || w_tick) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + TICK_W'(1);
      end
    end
  end

  // Sample sequencer: CNV pulse, SCK burst with MSB-first capture, output strobe, overrun flag
  always_ff @(posedge ADC_I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_state    <= S_IDLE;
      r_conv_cnt <= '0;
      r_div_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_cnv      <= 1'b0;
      r_sck      <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_valid <= 1'b0;

      // Sticky until the channel is disabled; a busy-time tick never disturbs the sample
      if (!bus.I_enable) begin
        r_overrun <= 1'b0;
      end else if (w_tick && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_state    <= S_CONV;
            r_cnv      <= 1'b1;
            r_busy     <= 1'b1;
            r_conv_cnt <= '0;
          end
        end

        S_CONV: begin
          if (r_conv_cnt == CONV_LAST) begin
            r_state   <= S_READ;
            r_cnv     <= 1'b0;
            r_sck     <= 1'b0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
          end else begin
            r_conv_cnt <= r_conv_cnt + CONV_W'(1);
          end
        end

        S_READ: begin
          if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            if (r_sck) begin
              // End of the high half: capture SDO as SCK is pulled back low
              r_sck   <= 1'b0;
              r_shift <= w_shift_nxt;
              if (r_bit_cnt == BIT_LAST) begin
                r_state <= S_DONE;
                r_data  <= w_shift_nxt;
                r_valid <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
              end
            end else begin
              r_sck <= 1'b1;
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cnv   <= 1'b0;
          r_sck   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ADC_O_cnv       = r_cnv;
  assign bus.ADC_O_sck       = r_sck;
  assign bus.ADC_O_data      = r_data;
  assign bus.ADC_O_dataValid = r_valid;
  assign bus.O_busy          = r_busy;
  assign bus.O_overrun       = r_overrun;

endmodule
